puf_eval_ctrl: RTL and testbench
================================

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 SHALL have parameter N, default 64: challenge width, equal to the delay-line stage count.
REQ-002 SHALL have parameter SETTLE, default 16: number of cycles launch is held before sampling, and held low before relaunch; legal range 2..255.
REQ-003 SHALL have parameter REPS, default 7: evaluations per challenge; legal values are odd, 1..31.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: request to evaluate challenge_in.
REQ-007 SHALL have port challenge_in, input, N bits: challenge, captured when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; response_out and ones_count are valid in that cycle.
REQ-010 SHALL have port response_out, output, 1 bit: majority-voted PUF response.
REQ-011 SHALL have port ones_count, output, 5 bits: number of samples equal to 1 in the last evaluation (reliability metric).
REQ-012 SHALL have port puf_launch, output, 1 bit: launch edge to the delay line.
REQ-013 SHALL have port puf_challenge, output, N bits: registered challenge driving the delay-line selects.
REQ-014 SHALL have port puf_response, input, 1 bit: asynchronous arbiter output.

Function
REQ-015 SHALL synchronize puf_response through 2 flops before any use.
REQ-016 SHALL implement the FSM states IDLE, LOAD, LAUNCH, SETTLE, SAMPLE, RECOVER and DONE.
REQ-017 SHALL accept start only in IDLE; start in any other state is ignored and has no side effect.
REQ-018 IDLE with start=1 SHALL, on that edge, latch challenge_in into puf_challenge, clear the ones and rep counters, and go to LOAD.
REQ-019 LOAD SHALL last 1 cycle with puf_launch=0, letting the selects settle, and then go to LAUNCH.
REQ-020 LAUNCH SHALL last 1 cycle, drive puf_launch=1, and go to SETTLE.
REQ-021 SETTLE SHALL hold puf_launch=1 for exactly SETTLE cycles, counted by the wait counter, and then go to SAMPLE.
REQ-022 SAMPLE SHALL hold puf_launch=1, add the synchronized response to the ones counter, and go to RECOVER.
REQ-023 RECOVER SHALL drive puf_launch=0 for SETTLE cycles, then go to LAUNCH if rep < REPS-1 (with rep incremented), otherwise to DONE.
REQ-024 DONE SHALL last 1 cycle, assert done, set response_out = (ones > REPS/2), update ones_count, and return to IDLE.
REQ-025 SHALL assert done exactly 2 + REPS*(2*SETTLE+2) cycles after the edge that accepts start.
REQ-026 The ones counter SHALL saturate at REPS and never wrap.
REQ-027 SHALL hold response_out and ones_count stable from DONE until the next DONE.
REQ-028 SHALL hold puf_challenge constant from LOAD through DONE; it SHALL change only when start is accepted.
REQ-029 SHALL drive puf_launch from a flop, never combinationally from state decode.
REQ-030 start asserted in the DONE cycle SHALL be ignored; start asserted in the following IDLE cycle SHALL be accepted.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE and busy=0, done=0, response_out=0, ones_count=0, puf_launch=0 and puf_challenge=0, and SHALL clear all counters and synchronizer flops.
REQ-032 Reset asserted mid-evaluation SHALL abort it, produce no done pulse, and leave puf_launch low.
REQ-033 After rst_n rises, the first start SHALL be acceptable on the first clock edge.

Structure
REQ-034 Package puf_pkg SHALL hold the FSM state enum (puf_eval_state_t), default parameter constants, and the ones-counter width constant.
REQ-035 The 2-flop synchronizer SHALL be a sub-module named sync_2ff, which has an asynchronous active-low reset value of 0.
REQ-036 SHALL contain all other logic (FSM, wait counter, rep counter, ones counter) in puf_eval_ctrl.

Verification
REQ-037 Scenario: N=64, SETTLE=4, REPS=7, behavioural PUF model returning constant 1; start with challenge 64'hDEADBEEF_01234567 -> done at cycle 2+7*10=72, response_out=1, ones_count=7, and puf_challenge equal to the input throughout.
REQ-038 Scenario: model returns 1 on samples 1, 3, 5 and 0 otherwise -> ones_count=3, response_out=0; returns 1 on samples 1-4 -> ones_count=4, response_out=1.
REQ-039 Scenario: start pulsed again while busy with a different challenge -> ignored; puf_challenge unchanged; exactly one done pulse.
REQ-040 Scenario: rst_n pulled low during the third SETTLE -> puf_launch=0 and busy=0 immediately; no done pulse; a fresh start afterwards completes normally.
REQ-041 Scenario: back-to-back runs with start held high continuously -> a new evaluation is accepted on the IDLE cycle after each done; puf_launch shows exactly REPS rising edges per evaluation, each high for SETTLE+2 cycles.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and defaults for the arbiter-PUF evaluation controller.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_RECOVER,
    ST_DONE
  } puf_eval_state_t;

  localparam int DEF_N      = 64;
  localparam int DEF_SETTLE = 16;
  localparam int DEF_REPS   = 7;
  localparam int ONES_W     = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous arbiter output.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: repeated launch/sample
// of one challenge with a majority vote over REPS samples.
import puf_pkg::*;

module puf_eval_ctrl #(
  parameter int N      = DEF_N,
  parameter int SETTLE = DEF_SETTLE,
  parameter int REPS   = DEF_REPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N-1:0]      challenge_in,
  output logic              busy,
  output logic              done,
  output logic              response_out,
  output logic [ONES_W-1:0] ones_count,
  output logic              puf_launch,
  output logic [N-1:0]      puf_challenge,
  input  logic              puf_response
);

  localparam logic [7:0] WAIT_LAST = 8'(SETTLE - 1);
  localparam logic [4:0] REP_LAST  = 5'(REPS - 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(REPS);
  localparam logic [ONES_W-1:0] HALF     = ONES_W'(REPS / 2);

  puf_eval_state_t   state;
  logic [7:0]        wait_cnt;
  logic [4:0]        rep;
  logic [ONES_W-1:0] ones;
  logic              resp_sync;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (puf_response),
    .q     (resp_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      rep           <= '0;
      ones          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      response_out  <= 1'b0;
      ones_count    <= '0;
      puf_launch    <= 1'b0;
      puf_challenge <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            puf_challenge <= challenge_in;
            ones  <= '0;
            rep   <= '0;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          puf_launch <= 1'b1;
          state      <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          wait_cnt <= '0;
          state    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= ST_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_SAMPLE: begin
          if (resp_sync && ones != ONES_MAX) begin
            ones <= ones + 1'b1;
          end
          puf_launch <= 1'b0;
          wait_cnt   <= '0;
          state      <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + 8'd1;
          end else if (rep < REP_LAST) begin
            rep        <= rep + 5'd1;
            puf_launch <= 1'b1;
            state      <= ST_LAUNCH;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // outputs land one edge later, in the IDLE cycle
          done         <= 1'b1;
          response_out <= (ones > HALF);
          ones_count   <= ones;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl with a behavioural arbiter model.
module tb_puf_eval_ctrl;

  localparam int N   = 64;
  localparam int ST  = 4;
  localparam int RP  = 7;
  localparam int LAT = 2 + RP * (2 * ST + 2);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  challenge_in;
  logic          busy;
  logic          done;
  logic          response_out;
  logic [4:0]    ones_count;
  logic          puf_launch;
  logic [N-1:0]  puf_challenge;
  logic          puf_response;

  int checks;
  int failures;
  int launch_cnt;
  logic [31:0] pat;

  puf_eval_ctrl #(
    .N      (N),
    .SETTLE (ST),
    .REPS   (RP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .challenge_in  (challenge_in),
    .busy          (busy),
    .done          (done),
    .response_out  (response_out),
    .ones_count    (ones_count),
    .puf_launch    (puf_launch),
    .puf_challenge (puf_challenge),
    .puf_response  (puf_response)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // arbiter model: bit k of pat is the outcome of launch k+1
  always @(posedge puf_launch) begin
    puf_response = pat[launch_cnt[4:0]];
    launch_cnt   = launch_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept start, then return edges until done (0 on timeout)
  task automatic run_eval(input logic [N-1:0] ch,
                          output int lat, output logic ch_ok);
    lat   = 0;
    ch_ok = 1'b1;
    launch_cnt   = 0;
    start        = 1'b1;
    challenge_in = ch;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (puf_challenge !== ch) ch_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    challenge_in = '0;
    puf_response = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, response_out, puf_launch} !== 4'b0) begin
      $display("FAIL reset_flags got=%b want=0000",
               {busy, done, response_out, puf_launch});
      failures++;
    end
    checks++;
    if (ones_count !== 5'd0 || puf_challenge !== '0) begin
      $display("FAIL reset_data ones=%0d chal=%h want 0",
               ones_count, puf_challenge);
      failures++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_const_one();
    int lat;
    logic ok;
    pat = 32'hFFFF_FFFF;
    run_eval(64'hDEADBEEF_01234567, lat, ok);
    checks++;
    if (lat !== LAT) begin
      $display("FAIL const_latency got=%0d want=%0d", lat, LAT);
      failures++;
    end
    checks++;
    if (response_out !== 1'b1 || ones_count !== 5'd7) begin
      $display("FAIL const_result resp=%b ones=%0d want 1/7",
               response_out, ones_count);
      failures++;
    end
    checks++;
    if (!ok) begin
      $display("FAIL const_challenge got=%h want=%h",
               puf_challenge, 64'hDEADBEEF_01234567);
      failures++;
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      $display("FAIL done_pulse got=%b want=0", done);
      failures++;
    end
  endtask

  task automatic test_pattern(input logic [31:0] p,
                              input logic [4:0] w_ones,
                              input logic w_resp);
    int lat;
    logic ok;
    pat = p;
    run_eval(64'h0123_4567_89AB_CDEF ^ 64'(p), lat, ok);
    checks++;
    if (lat !== LAT || ones_count !== w_ones ||
        response_out !== w_resp) begin
      $display("FAIL pattern_%h lat=%0d ones=%0d resp=%b want %0d/%0d/%b",
               p, lat, ones_count, response_out, LAT, w_ones, w_resp);
      failures++;
    end
    repeat (5) tick();
    checks++;
    if (ones_count !== w_ones || response_out !== w_resp) begin
      $display("FAIL hold_%h ones=%0d resp=%b want %0d/%b",
               p, ones_count, response_out, w_ones, w_resp);
      failures++;
    end
  endtask

  task automatic test_start_ignored();
    int ndone;
    int lat;
    ndone = 0;
    lat   = 0;
    pat   = 32'hFFFF_FFFF;
    launch_cnt   = 0;
    start        = 1'b1;
    challenge_in = 64'hAAAA_0000_5555_1111;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      if (k == 10) begin
        start = 1'b1;
        challenge_in = 64'h1234_5678_9ABC_DEF0;
      end
      if (k == 12) start = 1'b0;
      tick();
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
    end
    checks++;
    if (ndone !== 1 || lat !== LAT) begin
      $display("FAIL busy_start dones=%0d lat=%0d want 1/%0d",
               ndone, lat, LAT);
      failures++;
    end
    checks++;
    if (puf_challenge !== 64'hAAAA_0000_5555_1111) begin
      $display("FAIL busy_chal got=%h want=%h",
               puf_challenge, 64'hAAAA_0000_5555_1111);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    int lat;
    logic ok;
    ndone = 0;
    pat   = 32'hFFFF_FFFF;
    launch_cnt   = 0;
    start        = 1'b1;
    challenge_in = 64'hCAFE_F00D_0000_0001;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100 && launch_cnt < 3; k++) tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (puf_launch !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL mid_reset launch=%b busy=%b done=%b want 0",
               puf_launch, busy, done);
      failures++;
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      $display("FAIL mid_nodone got=%0d want=0", ndone);
      failures++;
    end
    pat = 32'h0000_0015;
    run_eval(64'h0F0F_0F0F_0F0F_0F0F, lat, ok);
    checks++;
    if (lat !== LAT || ones_count !== 5'd3 || !ok) begin
      $display("FAIL mid_rerun lat=%0d ones=%0d ok=%b want %0d/3/1",
               lat, ones_count, ok, LAT);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, rises, run, bad_runs;
    logic prev;
    d1 = 0;
    d2 = 0;
    rises = 0;
    run = 0;
    bad_runs = 0;
    prev = 1'b0;
    pat = 32'hFFFF_FFFF;
    launch_cnt   = 0;
    start        = 1'b1;
    challenge_in = 64'h5A5A_5A5A_A5A5_A5A5;
    tick();
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (puf_launch && !prev) rises++;
      if (puf_launch) run++;
      else if (run > 0) begin
        if (run != ST + 2) bad_runs++;
        run = 0;
      end
      prev = puf_launch;
      if (done) begin
        if (d1 == 0) d1 = k;
        else begin
          d2 = k;
          start = 1'b0;
          break;
        end
      end
    end
    checks++;
    if (d1 !== LAT || d2 !== 2 * LAT + 1) begin
      $display("FAIL b2b_done d1=%0d d2=%0d want %0d/%0d",
               d1, d2, LAT, 2 * LAT + 1);
      failures++;
    end
    checks++;
    if (rises !== 2 * RP || bad_runs !== 0) begin
      $display("FAIL b2b_launch rises=%0d bad=%0d want %0d/0",
               rises, bad_runs, 2 * RP);
      failures++;
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL b2b_idle busy=%b want 0", busy);
      failures++;
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    launch_cnt = 0;
    pat        = '0;
    test_reset();
    test_const_one();
    test_pattern(32'h0000_0015, 5'd3, 1'b0);
    test_pattern(32'h0000_000F, 5'd4, 1'b1);
    test_pattern(32'h0000_0000, 5'd0, 1'b0);
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
